led_pwm_fader: RTL

//  Downstream of the LED PIO register: takes its 8-bit out_port and drives the board LEDs.

---
 rtl/led_pwm_fader_pkg.sv | 35 +++
 rtl/led_pwm_fader_channel.sv | 94 +++++++++
 rtl/led_pwm_fader.sv | 88 ++++++++
 3 files changed

// File: rtl/led_pwm_fader_pkg.sv
// -----------------------------------------------------------------------------
// led_pwm_fader_pkg
// Shared definitions for the LED PWM fader:
//   - fade_state_e : per-channel fade FSM state encoding
//   - sat_add      : saturating add, clamps at max_val
//   - sat_sub      : saturating subtract, clamps at 0
// The helpers work on 32-bit unsigned values so they can serve any brightness
// width up to 31 bits; callers zero-extend their operands and truncate the result.
// -----------------------------------------------------------------------------
package led_pwm_fader_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RISE = 2'd1,
    ST_ON   = 2'd2,
    ST_FALL = 2'd3
  } fade_state_e;

  // The sum is formed one bit wider than the operands so a step past the top
  // cannot wrap around before the clamp is applied.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] step,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, step};
    return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
  endfunction

  // Borrow check: a step larger than the current value lands on zero.
  function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                          input logic [31:0] step);
    return (a < step) ? 32'd0 : (a - step);
  endfunction

endpackage

// File: rtl/led_pwm_fader_channel.sv
// -----------------------------------------------------------------------------
// led_pwm_fader_channel
// One LED: fade FSM, brightness register and PWM compare.
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   target_on  in   1: target is full brightness, 0: target is dark
//   fade_en    in   1: ramp on fade_tick, 0: jump to target next clk
//   fade_tick  in   one-cycle fade step strobe
//   pwm_cnt    in   shared free-running PWM counter
//   bright     out  current brightness
//   led        out  registered PWM drive
//   at_target  out  brightness equals the current target (combinational)
// -----------------------------------------------------------------------------
module led_pwm_fader_channel
  import led_pwm_fader_pkg::*;
#(
  parameter int BRIGHT_W  = 8,
  parameter int FADE_STEP = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                target_on,
  input  logic                fade_en,
  input  logic                fade_tick,
  input  logic [BRIGHT_W-1:0] pwm_cnt,
  output logic [BRIGHT_W-1:0] bright,
  output logic                led,
  output logic                at_target
);

  localparam logic [BRIGHT_W-1:0] MAX    = '1;
  localparam logic [31:0]         MAX32  = 32'(MAX);
  localparam logic [31:0]         STEP32 = 32'(FADE_STEP);

  fade_state_e         r_state;
  fade_state_e         w_state_next;
  fade_state_e         w_dir;
  logic [BRIGHT_W-1:0] r_bright;
  logic [BRIGHT_W-1:0] w_bright_next;
  logic [BRIGHT_W-1:0] w_target;
  logic                r_led;

  assign w_target = target_on ? MAX : '0;

  always_comb begin
    w_dir         = r_state;
    w_state_next  = r_state;
    w_bright_next = r_bright;
    if (!fade_en) begin
      w_bright_next = w_target;
      w_state_next  = target_on ? ST_ON : ST_OFF;
    end else begin
      // Resolve the direction from the target first, so a target change that
      // coincides with fade_tick already steps the new way (reversal keeps the
      // current brightness as the starting point).
      if (target_on && (r_state == ST_OFF || r_state == ST_FALL)) begin
        w_dir = ST_RISE;
      end else if (!target_on && (r_state == ST_ON || r_state == ST_RISE)) begin
        w_dir = ST_FALL;
      end
      w_state_next = w_dir;
      if (fade_tick && w_dir == ST_RISE) begin
        w_bright_next = BRIGHT_W'(sat_add(32'(r_bright), STEP32, MAX32));
        if (w_bright_next == MAX) begin
          w_state_next = ST_ON;
        end
      end else if (fade_tick && w_dir == ST_FALL) begin
        w_bright_next = BRIGHT_W'(sat_sub(32'(r_bright), STEP32));
        if (w_bright_next == '0) begin
          w_state_next = ST_OFF;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_OFF;
      r_bright <= '0;
      r_led    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_bright <= w_bright_next;
      // Full scale is forced on so MAX gives a solid 100% instead of 255/256.
      r_led    <= (r_bright == MAX) | (r_bright > pwm_cnt);
    end
  end

  assign bright    = r_bright;
  assign led       = r_led;
  assign at_target = (r_bright == w_target);

endmodule

// File: rtl/led_pwm_fader.sv
// -----------------------------------------------------------------------------
// led_pwm_fader
// Turns the LED PIO out_port into faded, PWM-dimmed LED drive.
// Ports:
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   level_in  in   per-LED on/off target from the PIO (same clock domain)
//   fade_en   in   1: ramp brightness, 0: brightness follows target at once
//   led_out   out  registered PWM drive for each LED
//   busy      out  registered, high while any channel is away from its target
// The top owns the PWM and fade prescalers, the shared PWM counter and the
// busy reduction; per-LED work lives in led_pwm_fader_channel.
// -----------------------------------------------------------------------------
module led_pwm_fader
  import led_pwm_fader_pkg::*;
#(
  parameter int N_LED     = 8,
  parameter int BRIGHT_W  = 8,
  parameter int PWM_DIV   = 4,
  parameter int FADE_DIV  = 50000,
  parameter int FADE_STEP = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_LED-1:0] level_in,
  input  logic             fade_en,
  output logic [N_LED-1:0] led_out,
  output logic             busy
);

  localparam int PWM_PRE_W  = (PWM_DIV  > 1) ? $clog2(PWM_DIV)  : 1;
  localparam int FADE_PRE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  logic [PWM_PRE_W-1:0]  r_pwm_pre;
  logic [FADE_PRE_W-1:0] r_fade_pre;
  logic [BRIGHT_W-1:0]   r_pwm_cnt;
  logic                  r_busy;
  logic                  w_pwm_tick;
  logic                  w_fade_tick;
  logic [N_LED-1:0]      w_led;
  logic [N_LED-1:0]      w_at_target;
  logic [BRIGHT_W-1:0]   w_bright [N_LED];

  // Ticks are decoded from the terminal count, so a divider of 1 gives a
  // strobe on every clock.
  assign w_pwm_tick  = (r_pwm_pre  == PWM_PRE_W'(PWM_DIV - 1));
  assign w_fade_tick = (r_fade_pre == FADE_PRE_W'(FADE_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_pre  <= '0;
      r_fade_pre <= '0;
      r_pwm_cnt  <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_pwm_pre  <= w_pwm_tick  ? '0 : r_pwm_pre  + PWM_PRE_W'(1);
      r_fade_pre <= w_fade_tick ? '0 : r_fade_pre + FADE_PRE_W'(1);
      if (w_pwm_tick) begin
        r_pwm_cnt <= r_pwm_cnt + BRIGHT_W'(1);  // wraps MAX -> 0
      end
      r_busy <= ~&w_at_target;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_LED; gi++) begin : g_ch
      led_pwm_fader_channel #(
        .BRIGHT_W  (BRIGHT_W),
        .FADE_STEP (FADE_STEP)
      ) u_ch (
        .clk       (clk),
        .reset_n   (reset_n),
        .target_on (level_in[gi]),
        .fade_en   (fade_en),
        .fade_tick (w_fade_tick),
        .pwm_cnt   (r_pwm_cnt),
        .bright    (w_bright[gi]),
        .led       (w_led[gi]),
        .at_target (w_at_target[gi])
      );
    end
  endgenerate

  assign led_out = w_led;
  assign busy    = r_busy;

endmodule
